// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with oversampling bit recovery and a 16-entry
// receive FIFO. Good bytes are queued for the host; framing errors and
// overruns are reported as single-cycle pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       pop,
  output logic [7:0] data_out,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic [4:0] count,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int H   = CLKS_PER_BIT / 2;
  localparam int BCW = $clog2(CLKS_PER_BIT);

  // Mid start bit and end of a full bit period, in bit-counter units.
  localparam logic [BCW-1:0] BC_MID  = BCW'(H - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer flops; both idle high so reset never looks like a start bit.
  logic rx_meta_reg;
  logic rx_s_reg;

  // Receiver state.
  state_t         state_reg;
  logic [BCW-1:0] bc_reg;
  logic [2:0]     bi_reg;
  logic [7:0]     shift_reg;
  logic           frame_err_reg;

  // FIFO state. Storage has no reset: the count alone decides validity.
  logic [7:0] mem [16];
  logic [3:0] wr_ptr_reg;
  logic [3:0] rd_ptr_reg;
  logic [4:0] count_reg;
  logic       overrun_reg;

  // Write attempt happens on the stop-sample edge when the stop bit is high.
  logic wr_try;
  logic wr_accept;
  logic rd_accept;

  // Two-flop synchronizer for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // Frame FSM: find start edge, verify mid start bit, sample 8 data bits and
  // the stop bit at bit-period intervals from the verified start point.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bc_reg        <= '0;
      bi_reg        <= 3'd0;
      shift_reg     <= 8'h00;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_s_reg) begin
            state_reg <= START;
            bc_reg    <= '0;
          end
        end
        START: begin
          if (bc_reg == BC_MID) begin
            if (rx_s_reg) begin
              // Line went back high before mid start bit: treat as glitch.
              state_reg <= IDLE;
            end else begin
              state_reg <= DATA;
              bc_reg    <= '0;
              bi_reg    <= 3'd0;
            end
          end else begin
            bc_reg <= bc_reg + BCW'(1);
          end
        end
        DATA: begin
          if (bc_reg == BC_LAST) begin
            // LSB arrives first, so shift in from the top.
            shift_reg <= {rx_s_reg, shift_reg[7:1]};
            bc_reg    <= '0;
            if (bi_reg == 3'd7) begin
              state_reg <= STOP;
            end else begin
              bi_reg <= bi_reg + 3'd1;
            end
          end else begin
            bc_reg <= bc_reg + BCW'(1);
          end
        end
        STOP: begin
          if (bc_reg == BC_LAST) begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            frame_err_reg <= !rx_s_reg;
            state_reg     <= IDLE;
          end else begin
            bc_reg <= bc_reg + BCW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wr_try    = (state_reg == STOP) && (bc_reg == BC_LAST) && rx_s_reg;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_accept = wr_try && ((count_reg != 5'd16) || pop);
  // Pop on an empty FIFO is ignored, even when a write lands the same cycle.
  assign rd_accept = pop && (count_reg != 5'd0);

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= 4'd0;
      rd_ptr_reg  <= 4'd0;
      count_reg   <= 5'd0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= wr_try && (count_reg == 5'd16) && !pop;
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 4'd1;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + 4'd1;
      end
      if (wr_accept && !rd_accept) begin
        count_reg <= count_reg + 5'd1;
      end else if (!wr_accept && rd_accept) begin
        count_reg <= count_reg - 5'd1;
      end
    end
  end

  assign data_out   = (count_reg == 5'd0) ? 8'h00 : mem[rd_ptr_reg];
  assign fifo_empty = (count_reg == 5'd0);
  assign fifo_full  = (count_reg == 5'd16);
  assign count      = count_reg;
  assign rx_busy    = (state_reg != IDLE);
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit. Inputs change
// on the falling edge, outputs are sampled on the falling edge.
module tb_uart_rx;

  localparam int N        = 16;
  localparam int H        = N / 2;
  localparam int STOP_OFS = 2 + H + 9 * N;  // E0 to stop-sample edge

  logic       clk;
  logic       rst;
  logic       rx;
  logic       pop;
  logic [7:0] data_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] count;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .pop        (pop),
    .data_out   (data_out),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .count      (count),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running totals of error pulses across the whole run.
  always @(posedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
  end

  // Drive one 8N1 frame; must be called on a falling edge, returns on one.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    $display("tx frame 0x%02h stop=%0b", d, stop_bit);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    rx = stop_bit;
    repeat (N) @(negedge clk);
    rx = 1'b1;
  endtask

  // Pop one byte; called on a falling edge, returns on the next one.
  task automatic pop_one;
    $display("pop head 0x%02h count %0d", data_out, count);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    pop = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %02h want 00", data_out); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    $display("reset done");
  endtask

  task automatic test_single_byte;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        @(posedge clk);                       // E0
        repeat (STOP_OFS - 1) @(posedge clk);
        @(negedge clk);                       // just before stop-sample edge
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL single_pre_count: got %0d want 0", count); end
        n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL single_pre_busy: got %b want 1", rx_busy); end
        @(negedge clk);                       // just after stop-sample edge
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
        n_cmp++; if (data_out !== 8'h5A) begin n_err++; $display("FAIL single_data: got %02h want 5a", data_out); end
        n_cmp++; if (fifo_empty !== 1'b0) begin n_err++; $display("FAIL single_empty: got %b want 0", fifo_empty); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b want 0", rx_busy); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL single_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL single_overrun: got %b want 0", overrun); end
      end
    join
    pop_one();
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL single_pop_count: got %0d want 0", count); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL single_pop_data: got %02h want 00", data_out); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL single_pop_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_fill_wrap;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", fifo_full); end
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (data_out !== 8'(i)) begin n_err++; $display("FAIL fill_pop_data: got %02h want %02h", data_out, 8'(i)); end
      pop_one();
    end
    for (int i = 16; i < 20; i++) send_frame(8'(i), 1'b1);
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL wrap_count: got %0d want 16", count); end
    for (int i = 4; i < 20; i++) begin
      n_cmp++; if (data_out !== 8'(i)) begin n_err++; $display("FAIL wrap_data: got %02h want %02h", data_out, 8'(i)); end
      n_cmp++; if (count !== 5'(20 - i)) begin n_err++; $display("FAIL wrap_count_dec: got %0d want %0d", count, 20 - i); end
      pop_one();
    end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b1);
    n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovr_fill_count: got %0d want 16", count); end
    // Full with no pop: byte dropped, single-cycle pulse.
    fork
      send_frame(8'hAA, 1'b1);
      begin
        @(posedge clk);
        repeat (STOP_OFS - 1) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        @(negedge clk);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovr_count: got %0d want 16", count); end
        n_cmp++; if (data_out !== 8'h20) begin n_err++; $display("FAIL ovr_head: got %02h want 20", data_out); end
        @(negedge clk);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_width: got %b want 0", overrun); end
      end
    join
    // Full with pop on the stop-sample edge: write accepted, no overrun.
    fork
      send_frame(8'hAA, 1'b1);
      begin
        @(posedge clk);
        repeat (STOP_OFS - 1) @(posedge clk);
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pop_pulse: got %b want 0", overrun); end
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovr_pop_count: got %0d want 16", count); end
        n_cmp++; if (data_out !== 8'h21) begin n_err++; $display("FAIL ovr_pop_head: got %02h want 21", data_out); end
      end
    join
    n_cmp++; if (ov_cnt !== 1) begin n_err++; $display("FAIL ovr_total: got %0d want 1", ov_cnt); end
    for (int i = 1; i < 16; i++) begin
      n_cmp++; if (data_out !== 8'(8'h20 + i)) begin n_err++; $display("FAIL ovr_drain: got %02h want %02h", data_out, 8'(8'h20 + i)); end
      pop_one();
    end
    n_cmp++; if (data_out !== 8'hAA) begin n_err++; $display("FAIL ovr_last: got %02h want aa", data_out); end
    pop_one();
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL ovr_drain_empty: got %b want 1", fifo_empty); end
  endtask

  task automatic test_framing;
    fork
      send_frame(8'h33, 1'b0);
      begin
        @(posedge clk);
        repeat (STOP_OFS - 1) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_pre: got %b want 0", frame_err); end
        @(negedge clk);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL ferr_count: got %0d want 0", count); end
        @(negedge clk);
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_width: got %b want 0", frame_err); end
      end
    join
    // Low stop bit re-triggers a start that is then rejected as a glitch.
    repeat (2 * N) @(negedge clk);
    n_cmp++; if (fe_cnt !== 1) begin n_err++; $display("FAIL ferr_total: got %0d want 1", fe_cnt); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_idle: got %b want 0", rx_busy); end
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL ferr_count_after: got %0d want 0", count); end
  endtask

  task automatic test_glitch;
    $display("tx glitch 4 cycles low");
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);            // after edge E0+9
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy: got %b want 1", rx_busy); end
    @(negedge clk);                       // after start-sample edge E0+10
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_idle: got %b want 0", rx_busy); end
    repeat (N) @(negedge clk);
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL glitch_count: got %0d want 0", count); end
    n_cmp++; if (fe_cnt !== 1) begin n_err++; $display("FAIL glitch_ferr: got %0d want 1", fe_cnt); end
    n_cmp++; if (ov_cnt !== 1) begin n_err++; $display("FAIL glitch_ovr: got %0d want 1", ov_cnt); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    d = 8'h55;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL mid_pre_count: got %0d want 2", count); end
    $display("tx frame 0x%02h aborted by reset in bit 3", d);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    rx = d[3];
    repeat (H) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b want 1", rx_busy); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", count); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL mid_rst_empty: got %b want 1", fifo_empty); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL mid_rst_full: got %b want 0", fifo_full); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL mid_rst_data: got %02h want 00", data_out); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", rx_busy); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL mid_rst_ferr: got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovr: got %b want 0", overrun); end
    rx  = 1'b1;
    rst = 1'b0;
    repeat (3 * N) @(negedge clk);
    n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL mid_idle: got %b want 0", rx_busy); end
    send_frame(8'hC3, 1'b1);
    n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL mid_new_count: got %0d want 1", count); end
    n_cmp++; if (data_out !== 8'hC3) begin n_err++; $display("FAIL mid_new_data: got %02h want c3", data_out); end
    pop_one();
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL mid_pop_count: got %0d want 0", count); end
    pop_one();
    n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL empty_pop_count: got %0d want 0", count); end
    n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL empty_pop_empty: got %b want 1", fifo_empty); end
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL empty_pop_data: got %02h want 00", data_out); end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    pop = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_fill_wrap();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Run-time bound: the whole sequence needs well under 10k bit periods.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
